// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream_mux_rr channel multiplexer.
// Stats helpers are used only when STREAM_MUX_STATS_EN is defined.
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int STATS_CNT_W = 16;
    localparam logic [STATS_CNT_W-1:0] STATS_CNT_MAX = 16'hFFFF;

    // Saturating increment for the per-channel grant counters
    function automatic logic [STATS_CNT_W-1:0] sat_inc(input logic [STATS_CNT_W-1:0] v);
        return (v == STATS_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between upstream channels, the mux and the downstream sink.
// The slave modport is the mux side; the master modport drives it.
interface stream_mux_rr_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [SEL_W-1:0]      out_ch;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Rotating-priority arbiter: searches from ptr+1 cyclically and owns the
// pointer register, which is loaded with the winner on each update strobe.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             upd,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] r_ptr;

    // Cyclic search; descending k so the nearest request after r_ptr wins
    always_comb begin
        int c;
        c           = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            c = int'(r_ptr) + k;
            c = (c >= N) ? c - N : c;
            if (req[c]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(c);
            end else begin
                grant_valid = grant_valid;
                grant_idx   = grant_idx;
            end
        end
    end

    // Pointer reset to the last channel so channel 0 is served first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDX_W'(N - 1);
        end else if (upd) begin
            r_ptr <= grant_idx;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready mux with fixed or round-robin selection and a
// single-entry registered output stage. Optional stats: STREAM_MUX_STATS_EN.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    stream_mux_rr_if.slave              bus
`ifdef STREAM_MUX_STATS_EN
    ,
    input  logic                        stats_clr,
    output logic [N_CH*STATS_CNT_W-1:0] grant_cnt
`endif
);

    localparam int SEL_W = $clog2(N_CH);

    logic             w_can_accept;
    logic             w_fix_valid;
    logic             w_arb_valid;
    logic [SEL_W-1:0] w_arb_idx;
    logic             w_gnt_valid;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_xfer;
    logic             w_rr_mode;
    logic [N_CH-1:0]  w_in_ready;
    logic [WIDTH-1:0] w_gnt_data;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;

    rr_arbiter #(.N(N_CH)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (bus.in_valid),
        .upd         (w_xfer && w_rr_mode),
        .grant_valid (w_arb_valid),
        .grant_idx   (w_arb_idx)
    );

    // Fixed-mode grant: out-of-range sel matches no channel and never grants
    always_comb begin
        w_fix_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            w_fix_valid = (bus.sel == SEL_W'(i)) ? bus.in_valid[i] : w_fix_valid;
        end
    end

    // Grant source select, handshake and winning data mux
    always_comb begin
        w_rr_mode    = (mode_e'(bus.mode) == MODE_RR);
        w_can_accept = !r_out_valid || bus.out_ready;
        if (w_rr_mode) begin
            w_gnt_valid = w_arb_valid;
            w_gnt_idx   = w_arb_idx;
        end else begin
            w_gnt_valid = w_fix_valid;
            w_gnt_idx   = bus.sel;
        end
        w_xfer     = w_gnt_valid && w_can_accept;
        w_in_ready = '0;
        w_gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_in_ready[i] = w_xfer && (w_gnt_idx == SEL_W'(i));
            w_gnt_data    = (w_gnt_idx == SEL_W'(i)) ? bus.in_data[i*WIDTH +: WIDTH] : w_gnt_data;
        end
    end

    // Output stage: reload on transfer, empty on a pop with nothing behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_ch    <= w_gnt_idx;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= r_out_data;
            r_out_ch    <= r_out_ch;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_data  <= r_out_data;
            r_out_ch    <= r_out_ch;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

`ifdef STREAM_MUX_STATS_EN
    logic [STATS_CNT_W-1:0] r_cnt [N_CH];

    // Per-channel accepted-transfer counters; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
        end else if (stats_clr) begin
            for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= w_in_ready[i] ? sat_inc(r_cnt[i]) : r_cnt[i];
            end
        end
    end

    // Flatten counters onto the packed output bus
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant_cnt[i*STATS_CNT_W +: STATS_CNT_W] = r_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomised self-checking bench for stream_mux_rr: a capacity-one FIFO model
// with a cyclic-priority grant rule, plus directed scenarios and an N_CH=3 instance.
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    typedef struct {
        logic [W-1:0] d;
        int           ch;
    } word_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    word_t q[$];
    int    m_ptr;

    stream_mux_rr_if #(.N_CH(N), .WIDTH(W)) bus ();
    stream_mux_rr_if #(.N_CH(3), .WIDTH(W)) bus3 ();

    stream_mux_rr #(.N_CH(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    stream_mux_rr #(.N_CH(3), .WIDTH(W)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grant rule from the channel-selection description
    task automatic model_grant(input logic [N-1:0] v, input logic md, input logic [SW-1:0] s,
                               output bit gv, output int gi);
        gv = 1'b0;
        gi = 0;
        if (!md) begin
            gv = v[s];
            gi = int'(s);
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (v[c] && !gv) begin
                    gv = 1'b1;
                    gi = c;
                end
            end
        end
    endtask

    // One clock: drive, check at negedge against the model, advance the model
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic md,
                        input logic [SW-1:0] s, input logic ordy);
        bit            gv;
        int            gi;
        bit            can;
        bit            xfer;
        logic [N-1:0]  one;
        logic [N-1:0]  exp_rdy;
        word_t         w;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.mode      = md;
        bus.sel       = s;
        bus.out_ready = ordy;
        @(negedge clk);
        model_grant(v, md, s, gv, gi);
        can     = (q.size() == 0) || ordy;
        xfer    = gv && can;
        one     = 4'd1;
        exp_rdy = xfer ? (one << gi) : 4'd0;
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_data", bus.out_data, q[0].d);
            chk("out_ch", bus.out_ch, q[0].ch);
        end
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (xfer) begin
            w.d  = d[gi*W +: W];
            w.ch = gi;
            q.push_back(w);
            if (md) m_ptr = gi;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = N - 1;
    endtask

    initial begin
        logic [SW-1:0] exp_seq [5];
        logic [SW-1:0] alt_seq [4];
        logic [W-1:0]  held_d;
        logic [SW-1:0] held_ch;
        total = 0;
        bad   = 0;
        model_reset();
        rst_n          = 1'b0;
        bus.in_valid   = 4'd0;
        bus.in_data    = 32'd0;
        bus.mode       = 1'b1;
        bus.sel        = 2'd0;
        bus.out_ready  = 1'b1;
        bus3.in_valid  = 3'd0;
        bus3.in_data   = 24'd0;
        bus3.mode      = 1'b0;
        bus3.sel       = 2'd0;
        bus3.out_ready = 1'b1;

        // Reset values
        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 8'h00);
        chk("rst_out_ch", bus.out_ch, 2'd0);
        chk("rst_in_ready", bus.in_ready, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RR from reset with all channels valid: 0,1,2,3,0
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2;
        exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, $urandom, 1'b1, 2'd0, 1'b1);
            chk("rr_seq_valid", bus.out_valid, 1'b1);
            chk("rr_seq_ch", bus.out_ch, exp_seq[k]);
        end

        // Fixed select of channel 2
        step(4'b1111, 32'h44A52211, 1'b0, 2'd2, 1'b1);
        chk("fix_data", bus.out_data, 8'hA5);
        chk("fix_ch", bus.out_ch, 2'd2);

        // Fixed select of an idle channel: no grant, stage drains
        step(4'b1011, $urandom, 1'b0, 2'd2, 1'b1);
        step(4'b1011, $urandom, 1'b0, 2'd2, 1'b1);
        chk("fix_idle_valid", bus.out_valid, 1'b0);

        // Fill, stall five cycles, then pop and reload from channel 3
        step(4'b1111, $urandom, 1'b1, 2'd0, 1'b0);
        held_d  = bus.out_data;
        held_ch = bus.out_ch;
        for (int k = 0; k < 5; k++) begin
            step(4'($urandom), $urandom, 1'($urandom), 2'($urandom), 1'b0);
            chk("stall_data", bus.out_data, held_d);
            chk("stall_ch", bus.out_ch, held_ch);
        end
        step(4'b1000, 32'h9C000000, 1'b1, 2'd0, 1'b1);
        chk("reload_valid", bus.out_valid, 1'b1);
        chk("reload_ch", bus.out_ch, 2'd3);
        chk("reload_data", bus.out_data, 8'h9C);

        // RR alternation between channels 1 and 3
        alt_seq[0] = 2'd1; alt_seq[1] = 2'd3; alt_seq[2] = 2'd1; alt_seq[3] = 2'd3;
        for (int k = 0; k < 4; k++) begin
            step(4'b1010, $urandom, 1'b1, 2'd0, 1'b1);
            chk("rr_alt_ch", bus.out_ch, alt_seq[k]);
        end

        // Asynchronous reset while FULL, then lowest valid channel first
        step(4'b1010, $urandom, 1'b1, 2'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 1'b0);
        model_reset();
        bus.in_valid = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(4'b1010, $urandom, 1'b1, 2'd0, 1'b1);
        chk("post_rst_ch", bus.out_ch, 2'd1);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            step(4'($urandom), $urandom, 1'($urandom), 2'($urandom),
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        // Three-channel instance: sel=3 never grants, sel=2 does
        bus.in_valid   = 4'd0;
        bus.out_ready  = 1'b1;
        bus3.in_valid  = 3'b111;
        bus3.in_data   = 24'h7E3C11;
        bus3.mode      = 1'b0;
        bus3.sel       = 2'd3;
        bus3.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("n3_sel3_ready", bus3.in_ready, 3'd0);
            chk("n3_sel3_valid", bus3.out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        bus3.sel = 2'd2;
        @(negedge clk);
        chk("n3_sel2_ready", bus3.in_ready, 3'b100);
        @(posedge clk);
        #1;
        chk("n3_sel2_valid", bus3.out_valid, 1'b1);
        chk("n3_sel2_ch", bus3.out_ch, 2'd2);
        chk("n3_sel2_data", bus3.out_data, 8'h7E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
